// File: rtl/alioth_tb_pkg.sv
// Shared definitions for the alioth end-of-test monitor.
package alioth_tb_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ARMED  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } mon_state_t;

  localparam logic [31:0] PASS_VAL_DEF    = 32'd1;
  localparam logic [31:0] TOHOST_ADDR_DEF = 32'h000000a0;

endpackage

// File: rtl/addr_match_arb.sv
// Parallel watch-address comparators with a lowest-index-wins priority encoder.
module addr_match_arb #(
  parameter int unsigned PC_W = 32,
  parameter int unsigned N_CH = 2,
  parameter int unsigned CH_W = 1
) (
  input  logic [PC_W-1:0]      i_pc,
  input  logic [N_CH*PC_W-1:0] i_watch_addr,
  input  logic [N_CH-1:0]      i_watch_en,
  output logic                 o_match,
  output logic [CH_W-1:0]      o_idx
);

  logic [N_CH-1:0] w_eq;

  // Per-channel enabled address compare
  always_comb begin
    w_eq = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      w_eq[k] = i_watch_en[k] && (i_watch_addr[k*PC_W +: PC_W] == i_pc);
    end
  end

  // Pick the lowest matching channel
  always_comb begin
    o_match = 1'b0;
    o_idx   = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (w_eq[k] && !o_match) begin
        o_match = 1'b1;
        o_idx   = CH_W'(k);
      end
    end
  end

endmodule

// File: rtl/test_end_monitor.sv
// End-of-test detector: counts distinct arrivals at tohost addresses, then
// samples the result register after a settle window, or flags a timeout.
module test_end_monitor
  import alioth_tb_pkg::*;
#(
  parameter int unsigned  PC_W        = 32,
  parameter int unsigned  N_CH        = 2,
  parameter int unsigned  CNT_W       = 32,
  parameter int unsigned  HIT_THRESH  = 8,
  parameter int unsigned  TIMEOUT_BIT = 20,
  parameter int unsigned  SETTLE_CYC  = 4,
  parameter logic [31:0]  PASS_VAL    = PASS_VAL_DEF,
  localparam int unsigned CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic [PC_W-1:0]      pc_i,
  input  logic                 pc_vld_i,
  input  logic [N_CH*PC_W-1:0] watch_addr_i,
  input  logic [N_CH-1:0]      watch_en_i,
  input  logic                 to_dis_i,
  input  logic [31:0]          result_i,
  output logic [1:0]           state_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 fail_o,
  output logic                 timeout_o,
  output logic [CH_W-1:0]      first_ch_o,
  output logic [CNT_W-1:0]     first_cyc_o,
  output logic [CNT_W-1:0]     end_cyc_o,
  output logic [CNT_W-1:0]     hit_cnt_o,
  output logic [31:0]          result_o
);

  localparam int unsigned ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  mon_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cyc, r_hit_cnt, r_first_cyc, r_end_cyc;
  logic [PC_W-1:0]  r_last_pc;
  logic [ST_W-1:0]  r_settle;
  logic [CH_W-1:0]  r_first_ch;
  logic [31:0]      r_result;
  logic             r_done, r_pass, r_fail, r_timeout;

  logic             w_match, w_hit, w_thresh, w_to_raw;
  logic [CH_W-1:0]  w_idx;
  logic [CNT_W-1:0] w_hit_cnt_inc;
  logic             w_live, w_count_hit, w_first_hit, w_ld_settle;
  logic             w_settle_end, w_enter_done, w_to_taken;

  addr_match_arb #(
    .PC_W (PC_W),
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_arb (
    .i_pc         (pc_i),
    .i_watch_addr (watch_addr_i),
    .i_watch_en   (watch_en_i),
    .o_match      (w_match),
    .o_idx        (w_idx)
  );

  // A hit is a fresh valid arrival at an enabled watch address
  always_comb begin
    w_hit         = pc_vld_i && (pc_i != r_last_pc) && w_match;
    w_hit_cnt_inc = (r_hit_cnt == '1) ? r_hit_cnt : r_hit_cnt + CNT_W'(1);
    w_thresh      = w_hit && (w_hit_cnt_inc == CNT_W'(HIT_THRESH));
    w_to_raw      = !to_dis_i && r_cyc[TIMEOUT_BIT];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_state <= ST_RUN;
    else if (clr_i) r_state <= ST_RUN;
    else            r_state <= w_state_nxt;
  end

  // Next-state: timeout wins over threshold in RUN/ARMED
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN, ST_ARMED: begin
        if (w_to_raw)      w_state_nxt = ST_DONE;
        else if (w_thresh) w_state_nxt = ST_SETTLE;
        else if (w_hit)    w_state_nxt = ST_ARMED;
      end
      ST_SETTLE: if (r_settle == '0) w_state_nxt = ST_DONE;
      default:   w_state_nxt = r_state;
    endcase
  end

  // Per-state strobes that steer the counters and result capture
  always_comb begin
    state_o      = r_state;
    w_live       = (r_state == ST_RUN) || (r_state == ST_ARMED);
    w_count_hit  = w_live && w_hit;
    w_first_hit  = (r_state == ST_RUN) && w_hit;
    w_to_taken   = w_live && w_to_raw;
    w_ld_settle  = w_live && w_thresh && !w_to_raw;
    w_settle_end = (r_state == ST_SETTLE) && (r_settle == '0);
    w_enter_done = w_to_taken || w_settle_end;
  end

  // Cycle, hit and settle counters plus PC history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc <= '0; r_hit_cnt <= '0; r_last_pc <= '0; r_settle <= '0;
    end else if (clr_i) begin
      r_cyc <= '0; r_hit_cnt <= '0; r_last_pc <= '0; r_settle <= '0;
    end else begin
      if (pc_vld_i) r_last_pc <= pc_i;
      if (r_state != ST_DONE && r_cyc != '1) r_cyc <= r_cyc + CNT_W'(1);
      if (w_count_hit) r_hit_cnt <= w_hit_cnt_inc;
      if (w_ld_settle) r_settle <= ST_W'(SETTLE_CYC - 1);
      else if (r_state == ST_SETTLE && r_settle != '0) r_settle <= r_settle - ST_W'(1);
    end
  end

  // First-hit capture and end-of-test result latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first_ch <= '0; r_first_cyc <= '0; r_end_cyc <= '0; r_result <= '0;
      r_done <= 1'b0; r_pass <= 1'b0; r_fail <= 1'b0; r_timeout <= 1'b0;
    end else if (clr_i) begin
      r_first_ch <= '0; r_first_cyc <= '0; r_end_cyc <= '0; r_result <= '0;
      r_done <= 1'b0; r_pass <= 1'b0; r_fail <= 1'b0; r_timeout <= 1'b0;
    end else begin
      if (w_first_hit) begin
        r_first_ch  <= w_idx;
        r_first_cyc <= r_cyc;
      end
      if (w_enter_done) begin
        r_done    <= 1'b1;
        r_result  <= result_i;
        r_end_cyc <= r_cyc;
        r_timeout <= w_to_taken;
        r_pass    <= !w_to_taken && (result_i == PASS_VAL);
        r_fail    <= w_to_taken || (result_i != PASS_VAL);
      end
    end
  end

  assign done_o      = r_done;
  assign pass_o      = r_pass;
  assign fail_o      = r_fail;
  assign timeout_o   = r_timeout;
  assign first_ch_o  = r_first_ch;
  assign first_cyc_o = r_first_cyc;
  assign end_cyc_o   = r_end_cyc;
  assign hit_cnt_o   = r_hit_cnt;
  assign result_o    = r_result;

endmodule
